// File: rtl/snake_body.sv
// snake_body: variable-length snake on a toroidal grid.
// Moves on step, grows on request, detects self-collision.
module snake_body #(
   parameter int COORD_W  = 9,
   parameter int MAX_LEN  = 16,
   parameter int INIT_LEN = 5,
   parameter int GRID_W   = 40,
   parameter int GRID_H   = 30,
   parameter int START_X  = 20,
   parameter int START_Y  = 15
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         step,
   input  logic [1:0]                   dir,
   input  logic                         grow,
   input  logic [$clog2(MAX_LEN)-1:0]   rd_idx,
   output logic [COORD_W-1:0]           rd_x,
   output logic [COORD_W-1:0]           rd_y,
   output logic                         rd_valid,
   output logic [COORD_W-1:0]           head_x,
   output logic [COORD_W-1:0]           head_y,
   output logic [$clog2(MAX_LEN+1)-1:0] length,
   output logic [1:0]                   cur_dir,
   output logic                         alive,
   output logic                         self_hit
);

   localparam int LEN_W = $clog2(MAX_LEN+1);
   localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W-1);
   localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H-1);
   localparam logic [COORD_W-1:0] C_ONE = COORD_W'(1);
   localparam logic [LEN_W-1:0]   L_MAX = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0]   L_ONE = LEN_W'(1);

   logic [COORD_W-1:0] seg_x_q [MAX_LEN];
   logic [COORD_W-1:0] seg_y_q [MAX_LEN];

   logic [LEN_W-1:0]   length_q, length_d;
   logic [1:0]         cur_dir_q, dir_d;
   logic               alive_q, alive_d;
   logic               self_hit_q, self_hit_d;
   logic               grow_pend_q, grow_pend_d;

   logic [COORD_W-1:0] nx, ny;
   logic               move, grow_take, growing, hit;
   logic [LEN_W-1:0]   lim;

   // Next head, legal direction, growth and collision decisions.
   always_comb begin
      dir_d = (dir == (cur_dir_q ^ 2'd2)) ? cur_dir_q : dir;
      nx    = seg_x_q[0];
      ny    = seg_y_q[0];
      unique case (dir_d)
         2'd0: nx = (seg_x_q[0] == X_MAX) ? '0 : seg_x_q[0] + C_ONE;
         2'd1: ny = (seg_y_q[0] == Y_MAX) ? '0 : seg_y_q[0] + C_ONE;
         2'd2: nx = (seg_x_q[0] == '0) ? X_MAX : seg_x_q[0] - C_ONE;
         2'd3: ny = (seg_y_q[0] == '0) ? Y_MAX : seg_y_q[0] - C_ONE;
      endcase

      move      = step & alive_q;
      grow_take = grow_pend_q | grow;
      growing   = grow_take & (length_q < L_MAX);
      // A growing snake keeps its tail, so the tail cell is also occupied.
      lim       = growing ? length_q : length_q - L_ONE;

      hit = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (seg_x_q[i] == nx && seg_y_q[i] == ny && LEN_W'(i) < lim) begin
            hit = 1'b1;
         end
      end

      length_d    = length_q;
      alive_d     = alive_q;
      self_hit_d  = 1'b0;
      grow_pend_d = grow_take;
      if (move) begin
         grow_pend_d = 1'b0;
         if (growing) begin
            length_d = length_q + L_ONE;
         end
         if (hit) begin
            alive_d    = 1'b0;
            self_hit_d = 1'b1;
         end
      end
   end

   // Segment storage: reset to a horizontal line, shift on every move.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            if (i < INIT_LEN) begin
               seg_x_q[i] <= COORD_W'(START_X - i);
               seg_y_q[i] <= COORD_W'(START_Y);
            end else begin
               seg_x_q[i] <= '0;
               seg_y_q[i] <= '0;
            end
         end
      end else if (move) begin
         seg_x_q[0] <= nx;
         seg_y_q[0] <= ny;
         for (int i = 1; i < MAX_LEN; i++) begin
            seg_x_q[i] <= seg_x_q[i-1];
            seg_y_q[i] <= seg_y_q[i-1];
         end
      end
   end

   // Scalar state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         length_q    <= LEN_W'(INIT_LEN);
         cur_dir_q   <= 2'd0;
         alive_q     <= 1'b1;
         self_hit_q  <= 1'b0;
         grow_pend_q <= 1'b0;
      end else begin
         length_q    <= length_d;
         cur_dir_q   <= dir_d;
         alive_q     <= alive_d;
         self_hit_q  <= self_hit_d;
         grow_pend_q <= grow_pend_d;
      end
   end

   assign rd_x     = seg_x_q[rd_idx];
   assign rd_y     = seg_y_q[rd_idx];
   assign rd_valid = LEN_W'(rd_idx) < length_q;
   assign head_x   = seg_x_q[0];
   assign head_y   = seg_y_q[0];
   assign length   = length_q;
   assign cur_dir  = cur_dir_q;
   assign alive    = alive_q;
   assign self_hit = self_hit_q;

endmodule

// File: tb/tb_snake_body.sv
// tb_snake_body: directed stimulus with a queued scoreboard.
// Instance A uses default length 5, instance B starts at length 4.
module tb_snake_body;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       step = 1'b0;
   logic       grow = 1'b0;
   logic [1:0] dir = 2'd0;
   logic [3:0] rd_idx = 4'd0;

   logic [8:0] a_rx, a_ry, a_hx, a_hy;
   logic [8:0] b_rx, b_ry, b_hx, b_hy;
   logic [4:0] a_len, b_len;
   logic [1:0] a_cd, b_cd;
   logic       a_rv, a_al, a_sh;
   logic       b_rv, b_al, b_sh;

   snake_body u_a (
      .clk(clk), .rst(rst), .step(step), .dir(dir), .grow(grow),
      .rd_idx(rd_idx), .rd_x(a_rx), .rd_y(a_ry), .rd_valid(a_rv),
      .head_x(a_hx), .head_y(a_hy), .length(a_len),
      .cur_dir(a_cd), .alive(a_al), .self_hit(a_sh)
   );

   snake_body #(.INIT_LEN(4)) u_b (
      .clk(clk), .rst(rst), .step(step), .dir(dir), .grow(grow),
      .rd_idx(rd_idx), .rd_x(b_rx), .rd_y(b_ry), .rd_valid(b_rv),
      .head_x(b_hx), .head_y(b_hy), .length(b_len),
      .cur_dir(b_cd), .alive(b_al), .self_hit(b_sh)
   );

   always #5 clk = ~clk;

   typedef struct {
      int tid;
      int sel;
      int hx, hy, len, al, sh, cd;
      int rdc, rx, ry, rv;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;
   logic stepped_q = 1'b0;

   task automatic chk(input int tid, input string nm,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL t%0d %s got %0d exp %0d", tid, nm, act, exp);
      end
   endtask

   // Monitor: a step edge means the DUT presents a new result.
   always @(posedge clk) stepped_q <= step & ~rst;

   always @(negedge clk) begin
      if (stepped_q) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected step result");
         end else begin
            e = q.pop_front();
            if (e.sel == 0) begin
               chk(e.tid, "head_x", 32'(a_hx), 32'(e.hx));
               chk(e.tid, "head_y", 32'(a_hy), 32'(e.hy));
               chk(e.tid, "length", 32'(a_len), 32'(e.len));
               chk(e.tid, "alive", 32'(a_al), 32'(e.al));
               chk(e.tid, "self_hit", 32'(a_sh), 32'(e.sh));
               chk(e.tid, "cur_dir", 32'(a_cd), 32'(e.cd));
               if (e.rdc != 0) begin
                  chk(e.tid, "rd_x", 32'(a_rx), 32'(e.rx));
                  chk(e.tid, "rd_y", 32'(a_ry), 32'(e.ry));
                  chk(e.tid, "rd_valid", 32'(a_rv), 32'(e.rv));
               end
            end else begin
               chk(e.tid, "b_head_x", 32'(b_hx), 32'(e.hx));
               chk(e.tid, "b_head_y", 32'(b_hy), 32'(e.hy));
               chk(e.tid, "b_length", 32'(b_len), 32'(e.len));
               chk(e.tid, "b_alive", 32'(b_al), 32'(e.al));
               chk(e.tid, "b_self_hit", 32'(b_sh), 32'(e.sh));
            end
         end
      end
   end

   task automatic do_step(input int tid, input logic [1:0] d,
                          input int hx, input int hy, input int len,
                          input int al, input int sh, input int cd,
                          input int sel = 0, input int rdc = 0,
                          input int rx = 0, input int ry = 0,
                          input int rv = 0);
      exp_t x;
      x.tid = tid; x.sel = sel;
      x.hx = hx; x.hy = hy; x.len = len;
      x.al = al; x.sh = sh; x.cd = cd;
      x.rdc = rdc; x.rx = rx; x.ry = ry; x.rv = rv;
      q.push_back(x);
      dir  = d;
      step = 1'b1;
      @(posedge clk);
      #1;
      step = 1'b0;
   endtask

   task automatic tick(input logic g);
      grow = g;
      @(posedge clk);
      #1;
      grow = 1'b0;
   endtask

   task automatic drain();
      repeat (3) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending %0d exp 0", q.size());
         q.delete();
      end
   endtask

   task automatic do_reset(input int tid);
      drain();
      rst  = 1'b1;
      step = 1'b0;
      grow = 1'b0;
      dir  = 2'd0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk(tid, "rst_head_x", 32'(a_hx), 32'd20);
      chk(tid, "rst_head_y", 32'(a_hy), 32'd15);
      chk(tid, "rst_length", 32'(a_len), 32'd5);
      chk(tid, "rst_cur_dir", 32'(a_cd), 32'd0);
      chk(tid, "rst_alive", 32'(a_al), 32'd1);
      chk(tid, "rst_self_hit", 32'(a_sh), 32'd0);
      chk(tid, "rst_b_length", 32'(b_len), 32'd4);
      rd_idx = 4'd4;
      #1;
      chk(tid, "rst_rd4_x", 32'(a_rx), 32'd16);
      chk(tid, "rst_rd4_y", 32'(a_ry), 32'd15);
      chk(tid, "rst_rd4_valid", 32'(a_rv), 32'd1);
      rd_idx = 4'd5;
      #1;
      chk(tid, "rst_rd5_valid", 32'(a_rv), 32'd0);
      rd_idx = 4'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // t1: three steps right, tail readout
      do_reset(1);
      rd_idx = 4'd4;
      do_step(1, 2'd0, 21, 15, 5, 1, 0, 0);
      do_step(1, 2'd0, 22, 15, 5, 1, 0, 0);
      do_step(1, 2'd0, 23, 15, 5, 1, 0, 0, 0, 1, 19, 15, 1);

      // t2: reversal ignored, then turn up
      do_reset(2);
      do_step(2, 2'd2, 21, 15, 5, 1, 0, 0);
      do_step(2, 2'd3, 21, 14, 5, 1, 0, 3);

      // t3: merged grows, then saturation at 16
      do_reset(3);
      tick(1'b1);
      tick(1'b1);
      do_step(3, 2'd0, 21, 15, 6, 1, 0, 0);
      do_step(3, 2'd0, 22, 15, 6, 1, 0, 0);
      for (int k = 0; k < 11; k++) begin
         tick(1'b1);
         do_step(3, 2'd0, 23 + k, 15, (7 + k > 16) ? 16 : 7 + k,
                 1, 0, 0);
      end
      rd_idx = 4'd15;
      do_step(3, 2'd0, 34, 15, 16, 1, 0, 0, 0, 1, 19, 15, 1);

      // t4: wrap right edge then top edge
      do_reset(4);
      for (int k = 1; k <= 20; k++) begin
         do_step(4, 2'd0, (20 + k) % 40, 15, 5, 1, 0, 0);
      end
      for (int k = 1; k <= 16; k++) begin
         do_step(4, 2'd3, 0, (k == 16) ? 29 : 15 - k, 5, 1, 0, 3);
      end

      // t5: down, left, up bites the body; then frozen
      do_reset(5);
      do_step(5, 2'd1, 20, 16, 5, 1, 0, 1);
      do_step(5, 2'd2, 19, 16, 5, 1, 0, 2);
      do_step(5, 2'd3, 19, 15, 5, 0, 1, 3);
      do_step(5, 2'd3, 19, 15, 5, 0, 0, 3);
      tick(1'b1);
      do_step(5, 2'd3, 19, 15, 5, 0, 0, 3);

      // t6: length-4 tail chase, then same loop while growing
      do_reset(6);
      do_step(6, 2'd1, 20, 16, 4, 1, 0, 1, 1);
      do_step(6, 2'd2, 19, 16, 4, 1, 0, 2, 1);
      do_step(6, 2'd3, 19, 15, 4, 1, 0, 3, 1);
      do_step(6, 2'd0, 20, 15, 4, 1, 0, 0, 1);
      do_step(6, 2'd1, 20, 16, 4, 1, 0, 1, 1);
      grow = 1'b1;
      @(posedge clk);
      #1;
      do_step(6, 2'd2, 19, 16, 5, 0, 1, 2, 1);
      grow = 1'b0;

      drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/snake_body.md
Name: snake_body

Overview:
- Parametrised successor to the fixed five-segment snake position tracker.
- Holds a variable-length snake body of up to MAX_LEN segments on a GRID_W x GRID_H toroidal grid.
- Advances one cell per pacemaker tick; handles growth, direction-reversal rejection, edge wrap-around and self-collision detection.
- Sits between the pacemaker (step source), the direction input logic, and the display/renderer, which reads segments through an indexed read port.

Parameters:
COORD_W, 9, width of each x/y coordinate
MAX_LEN, 16, maximum segment count (2..64)
INIT_LEN, 5, length after reset (2..MAX_LEN)
GRID_W, 40, grid width in cells; x range 0..GRID_W-1
GRID_H, 30, grid height in cells; y range 0..GRID_H-1
START_X, 20, head x after reset (>= INIT_LEN-1)
START_Y, 15, head y after reset

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
step  in  1  single-cycle move strobe from pacemaker
dir  in  2  requested direction: 0=right(+x), 1=down(+y), 2=left(-x), 3=up(-y)
grow  in  1  growth request; pulse or level
rd_idx  in  $clog2(MAX_LEN)  segment index for readout; 0 = head
rd_x  out  COORD_W  x of segment rd_idx (combinational)
rd_y  out  COORD_W  y of segment rd_idx (combinational)
rd_valid  out  1  rd_idx < length
head_x  out  COORD_W  registered head x
head_y  out  COORD_W  registered head y
length  out  $clog2(MAX_LEN+1)  current segment count
cur_dir  out  2  direction actually in effect
alive  out  1  0 after self-collision
self_hit  out  1  one-cycle pulse on the colliding step

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values:
  - seg[i] = (START_X-i, START_Y) for i < INIT_LEN; seg[i] = (0,0) otherwise.
  - length = INIT_LEN; cur_dir = 0; alive = 1; self_hit = 0; grow_pend = 0.
- Reset mid-operation aborts any move immediately.
- Direction:
  - dir is sampled every clk.
  - If dir is the opposite of cur_dir (dir == cur_dir ^ 2), it is ignored.
  - Otherwise cur_dir <= dir. This update may happen between steps.
- Grow:
  - grow high on any clk sets grow_pend. Multiple requests between steps merge into one.
  - grow_pend is cleared on the step that consumes it.
- Move, on clk edge with step=1 and alive=1:
  - new head = seg[0] + delta(cur_dir), using the dir value updated on this same edge if legal.
  - Wrap: x = GRID_W-1 + 1 -> 0; x = 0 - 1 -> GRID_W-1; same for y with GRID_H.
  - Shift: seg[i] <= seg[i-1] for 1 <= i < MAX_LEN; seg[0] <= new head.
  - If grow_pend and length < MAX_LEN: length increments. At MAX_LEN, growth is discarded and grow_pend still clears.
- Collision:
  - New head is compared against pre-move seg[0..L-2], where L = length. If growing this step, the comparison covers seg[0..L-1] (tail does not vacate).
  - On a match, the move still commits (head drawn into body), alive <= 0, and self_hit pulses high for exactly one clk.
  - The snake freezes thereafter; only rst revives it.
- step while alive=0: no effect; the grow latch still accepts requests.
- Latency:
  - head_x, head_y, length, alive, self_hit and cur_dir are valid the clk after the step edge.
  - The rd_* port is combinational from registered state.
- rd_idx >= length: rd_valid=0; rd_x/rd_y return the stale stored value and must not be rendered.
- All compares use unsigned COORD_W arithmetic; no intermediate exceeds COORD_W+1 bits.

Test Plan:
- Reset, then 3 steps with dir=0 -> head (23,15), seg[4]=(19,15), length=5, alive=1.
- From reset, dir=2 (reversal) then step -> cur_dir stays 0, head (21,15). Then dir=3, step -> head (21,14).
- grow pulsed twice between two steps -> length 5->6 only. Repeat 11 more grow+step pairs -> length saturates at 16, grow_pend clears.
- Wrap: drive right 20 steps from (20,15) -> head (0,15) on the 20th step. Then up 16 steps -> head y = 29 on the 16th.
- Collision: grow to length 5 path, then steps down, left, up -> self_hit high 1 cycle, alive=0. Further steps leave head unchanged.
- Tail-chase: length 4 in a 2x2 loop, no grow -> no self_hit. Same loop with grow asserted -> self_hit.
